instr_mem_ctrl: RTL and testbench
=================================

INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: instruction word width in bits.
REQ-002 Parameter DEPTH, default 64: number of instruction words stored (power of two, >= 4).
REQ-003 Parameter ADDR_W, default 32: byte address width.
REQ-004 Parameter NOP, default all zeros: word returned on fault and written during clear.
REQ-005 Reset and clock SHALL be one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst  in  1  synchronous active-low reset.
REQ-008 fetch_req  in  1  fetch request, sampled at clk edge.
REQ-009 fetch_addr  in  ADDR_W  byte address of the fetch.
REQ-010 stall  in  1  hold the current output word; blocks new fetches.
REQ-011 prog_we  in  1  program-load write strobe.
REQ-012 prog_addr  in  ADDR_W  byte address of the write.
REQ-013 prog_data  in  DATA_W  word to write.
REQ-014 instr  out  DATA_W  registered fetched word.
REQ-015 instr_valid  out  1  instr holds the result of an accepted fetch.
REQ-016 fault  out  1  accepted fetch was misaligned or out of range.
REQ-017 ready  out  1  clear is complete; fetches and writes are accepted.
REQ-018 prog_err  out  1  one-cycle pulse: prog write was dropped.

Function
REQ-019 The word index SHALL be addr[log2(DEPTH)+1:2]; an address is bad if addr[1:0]!=0 or addr>>2 >= DEPTH.
REQ-020 The FSM SHALL have two states, CLEAR and RUN.
REQ-021 CLEAR: each cycle write NOP to word clr_cnt, then increment clr_cnt; after the write of word DEPTH-1, go to RUN.
REQ-022 ready SHALL be 1 only in RUN; it rises on the DEPTH-th edge with rst=1.
REQ-023 A fetch SHALL be accepted when ready=1, fetch_req=1 and stall=0.
REQ-024 Latency SHALL be one cycle: on the accepting edge, instr <= mem[index], instr_valid <= 1, fault <= 0.
REQ-025 On a bad-address accept: instr <= NOP, instr_valid <= 1, fault <= 1.
REQ-026 With stall=1, instr, instr_valid and fault SHALL hold their values, regardless of fetch_req.
REQ-027 With stall=0 and no accepted fetch, instr_valid <= 0 and fault <= 0; instr holds.
REQ-028 In CLEAR, fetch_req SHALL be ignored and instr_valid stays 0.
REQ-029 A write SHALL occur when ready=1, prog_we=1 and prog_addr is good; it is independent of stall.
REQ-030 A dropped write SHALL pulse prog_err for one cycle and leave memory unchanged. A write is dropped on a bad prog_addr, or when prog_we=1 in CLEAR.
REQ-031 When a fetch and a write hit the same word in the same cycle, the fetch SHALL return the old contents (read-first); the new value is visible to the next fetch.

Reset
REQ-032 rst=0 at an edge SHALL force the following, in any state and mid-fetch included: state=CLEAR, clr_cnt=0, instr=NOP, instr_valid=0, fault=0, ready=0, prog_err=0.
REQ-033 Memory is not cleared while rst=0; the clear happens in CLEAR after rst returns high.
REQ-034 A reset asserted partway through CLEAR SHALL restart the clear from word 0.

Verification
REQ-035 Clear sequence, DEPTH=64: hold rst=0 for 2 cycles, then release -> ready=0 for edges 1-63 and ready=1 after the 64th edge; a fetch of 0x0FC then returns NOP.
REQ-036 Write then fetch: write 0x00221820 to 0x000, then fetch 0x000 -> next cycle instr=0x00221820, instr_valid=1, fault=0.
REQ-037 Faults: fetch 0x002 -> instr=NOP, fault=1. Fetch 0x100 -> fault=1. prog write to 0x101 -> prog_err=1 for one cycle, and memory is unchanged.
REQ-038 Stall: fetch 0x004 (data 0x8C4B0001), then stall=1 for 3 cycles with fetch_req=1 and addr 0x008 -> instr stays 0x8C4B0001 with valid=1; after stall drops, the next accept returns mem[2].
REQ-039 Read-first collision: mem[1]=0xAAAA0000; same cycle, fetch 0x004 and write 0x55550000 to 0x004 -> instr=0xAAAA0000; the next fetch of 0x004 -> 0x55550000.
REQ-040 Reset mid-operation: assert rst=0 during a CLEAR at word 20 and again with instr_valid=1 -> outputs return to reset values next edge, and the clear restarts and takes 64 edges.

Source files
------------

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: clears its word array to NOP after reset,
// then serves single-cycle registered fetches and program-load writes.
//
// Handshake: a fetch is accepted on a rising edge where ready=1, fetch_req=1
// and stall=0; the result appears on instr/instr_valid/fault after that edge.
// stall=1 freezes instr/instr_valid/fault. A write is accepted on any edge
// where ready=1, prog_we=1 and prog_addr is good, regardless of stall.
// Any other write attempt raises prog_err for exactly one cycle.
module instr_mem_ctrl #(
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 64,
    parameter int                ADDR_W = 32,
    parameter logic [DATA_W-1:0] NOP    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              stall,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fault,
    output logic              ready,
    output logic              prog_err,
    output logic              state_dbg
);

    localparam int                IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST    = IDX_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic             fetch_bad;
    logic             prog_bad;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] prog_idx;
    logic             prog_ok;

    // An address is bad when it is not word aligned or lies past the last word.
    assign fetch_bad = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> 2) >= DEPTH_A);
    assign prog_bad  = (prog_addr[1:0] != 2'b00)  || ((prog_addr >> 2) >= DEPTH_A);
    assign fetch_idx = fetch_addr[IDX_W+1:2];
    assign prog_idx  = prog_addr[IDX_W+1:2];
    assign prog_ok   = (state == RUN) && prog_we && !prog_bad;
    assign state_dbg = (state == RUN);

    // Word array: clear sweep in CLEAR, program loads in RUN, untouched in reset.
    // Nonblocking update makes a same-edge fetch see the old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= NOP;
            end else if (prog_ok) begin
                mem[prog_idx] <= prog_data;
            end
        end
    end

    // Control FSM with registered fetch result, ready and write-error pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= CLEAR;
            clr_cnt     <= '0;
            instr       <= NOP;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            ready       <= 1'b0;
            prog_err    <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt     <= clr_cnt + 1'b1;
                    instr_valid <= 1'b0;
                    fault       <= 1'b0;
                    prog_err    <= prog_we;
                    if (clr_cnt == LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    prog_err <= prog_we && prog_bad;
                    if (!stall) begin
                        if (fetch_req) begin
                            instr       <= fetch_bad ? NOP : mem[fetch_idx];
                            instr_valid <= 1'b1;
                            fault       <= fetch_bad;
                        end else begin
                            instr_valid <= 1'b0;
                            fault       <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: directed stimulus, a rule-level reference model
// checked every cycle, plus literal expectations at key points.
module tb_instr_mem_ctrl;

    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 64;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        stall = 1'b0;
    logic        prog_we = 1'b0;
    logic [31:0] prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fault;
    logic        ready;
    logic        prog_err;
    logic        state_dbg;

    int vectors = 0;
    int miscompares = 0;

    instr_mem_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP(NOP)
    ) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .instr(instr), .instr_valid(instr_valid), .fault(fault),
        .ready(ready), .prog_err(prog_err), .state_dbg(state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [DEPTH];
    int          m_edges = 0;     // rst=1 edges since the last reset edge
    logic        m_on = 1'b0;
    logic [31:0] m_instr = NOP;
    logic        m_valid = 1'b0;
    logic        m_fault = 1'b0;
    logic        m_perr = 1'b0;

    function automatic logic is_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    // Ready after DEPTH clean edges; fetch/write rules applied against the
    // pre-edge memory image so collisions read the old word.
    always @(posedge clk) begin
        if (!rst) begin
            m_on    <= 1'b1;
            m_edges <= 0;
            m_instr <= NOP;
            m_valid <= 1'b0;
            m_fault <= 1'b0;
            m_perr  <= 1'b0;
        end else if (m_edges < DEPTH) begin
            m_mem[m_edges] <= NOP;
            m_edges <= m_edges + 1;
            m_valid <= 1'b0;
            m_fault <= 1'b0;
            m_perr  <= prog_we;
        end else begin
            if (!stall) begin
                if (fetch_req) begin
                    m_instr <= is_bad(fetch_addr) ? NOP : m_mem[fetch_addr / 4];
                    m_valid <= 1'b1;
                    m_fault <= is_bad(fetch_addr);
                end else begin
                    m_valid <= 1'b0;
                    m_fault <= 1'b0;
                end
            end
            m_perr <= prog_we && is_bad(prog_addr);
            if (prog_we && !is_bad(prog_addr)) m_mem[prog_addr / 4] <= prog_data;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_on) begin
            check("m_instr", instr, m_instr);
            check("m_valid", 32'(instr_valid), 32'(m_valid));
            check("m_fault", 32'(fault), 32'(m_fault));
            check("m_ready", 32'(ready), 32'(m_edges >= DEPTH));
            check("m_prog_err", 32'(prog_err), 32'(m_perr));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        step();
        prog_we = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_req = 1'b1; fetch_addr = a;
        step();
        fetch_req = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int exp_edges);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!ready && n < 200);
        check(name, 32'(n), 32'(exp_edges));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_instr"}, instr, NOP);
        check({name, "_valid"}, 32'(instr_valid), 32'd0);
        check({name, "_fault"}, 32'(fault), 32'd0);
        check({name, "_ready"}, 32'(ready), 32'd0);
        check({name, "_perr"}, 32'(prog_err), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // reset held for two edges
        step();
        step();
        check_reset_outputs("rst");
        rst = 1'b1;

        // clear sweep: fetches ignored, a write attempt is dropped
        for (int e = 1; e <= DEPTH; e++) begin
            prog_we   = (e == 10);
            prog_addr = 32'h0;
            prog_data = 32'hDEAD_BEEF;
            fetch_req = (e <= 60);
            fetch_addr = 32'h0;
            step();
            if (e == 10) check("clr_prog_err", 32'(prog_err), 32'd1);
            if (e == 11) check("clr_prog_err_drop", 32'(prog_err), 32'd0);
            if (e == 30) check("clr_valid", 32'(instr_valid), 32'd0);
            if (e == 63) check("ready_e63", 32'(ready), 32'd0);
        end
        prog_we = 1'b0;
        fetch_req = 1'b0;
        check("ready_e64", 32'(ready), 32'd1);

        fetch(32'h0FC);
        check("top_word_nop", instr, NOP);
        check("top_word_valid", 32'(instr_valid), 32'd1);
        fetch(32'h000);
        check("dropped_clr_write", instr, NOP);

        // write then fetch
        write_word(32'h000, 32'h0022_1820);
        fetch(32'h000);
        check("wf_instr", instr, 32'h0022_1820);
        check("wf_valid", 32'(instr_valid), 32'd1);
        check("wf_fault", 32'(fault), 32'd0);

        // faults
        fetch(32'h002);
        check("misalign_instr", instr, NOP);
        check("misalign_fault", 32'(fault), 32'd1);
        fetch(32'h100);
        check("range_fault", 32'(fault), 32'd1);
        write_word(32'h101, 32'hFFFF_FFFF);
        check("bad_write_err", 32'(prog_err), 32'd1);
        step();
        check("bad_write_pulse", 32'(prog_err), 32'd0);
        fetch(32'h000);
        check("bad_write_mem", instr, 32'h0022_1820);

        // stall hold, with a write landing during the stall
        write_word(32'h004, 32'h8C4B_0001);
        write_word(32'h008, 32'h1234_5678);
        fetch_req = 1'b1; fetch_addr = 32'h004;
        step();
        check("stall_pre", instr, 32'h8C4B_0001);
        stall = 1'b1; fetch_addr = 32'h008;
        for (int i = 0; i < 3; i++) begin
            prog_we = (i == 1); prog_addr = 32'h00C; prog_data = 32'hCAFE_F00D;
            step();
            check("stall_hold", instr, 32'h8C4B_0001);
            check("stall_valid", 32'(instr_valid), 32'd1);
        end
        prog_we = 1'b0;
        stall = 1'b0;
        step();
        check("stall_release", instr, 32'h1234_5678);
        fetch_req = 1'b0;
        step();
        check("idle_valid", 32'(instr_valid), 32'd0);
        check("idle_instr_hold", instr, 32'h1234_5678);
        fetch(32'h00C);
        check("stall_write", instr, 32'hCAFE_F00D);

        // read-first collision
        write_word(32'h004, 32'hAAAA_0000);
        fetch_req = 1'b1; fetch_addr = 32'h004;
        prog_we = 1'b1; prog_addr = 32'h004; prog_data = 32'h5555_0000;
        step();
        prog_we = 1'b0;
        check("collide_old", instr, 32'hAAAA_0000);
        step();
        fetch_req = 1'b0;
        check("collide_new", instr, 32'h5555_0000);

        // reset partway through the clear
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (20) step();
        rst = 1'b0;
        step();
        check_reset_outputs("rst_clr20");
        rst = 1'b1;
        wait_ready("clear_restart_edges", DEPTH);

        // reset while a fetch result is valid
        write_word(32'h000, 32'h1111_2222);
        fetch_req = 1'b1; fetch_addr = 32'h000;
        step();
        check("pre_rst_instr", instr, 32'h1111_2222);
        rst = 1'b0;
        step();
        fetch_req = 1'b0;
        check_reset_outputs("rst_valid");
        rst = 1'b1;
        wait_ready("clear_again_edges", DEPTH);
        fetch(32'h000);
        check("recleared_word", instr, NOP);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // global time bound
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
